// File: rtl/fir_chan_sched.sv
// fir_chan_sched
//   Round-robin scheduler that time-shares one 4-tap moving-sum datapath
//   (sample + h0 + h1 + h2) among N channels. Each channel keeps a private
//   3-sample history. One sample is accepted per cycle and fed through a
//   2-stage adder pipeline. The pipeline returns a channel-tagged result
//   over valid/ready with backpressure.
//
// Parameters:
//   w   sample width (unsigned)
//   N   number of channels (N >= 2)
//   CW  channel index width, $clog2(N)
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset      synchronous active-high reset
//   chan_clr   per-channel history clear (only with FIR_SCHED_CLR_EN)
//   in_valid   per-channel sample valid
//   in_data    packed samples, channel c at [c*w +: w]
//   in_ready   one-hot grant (all-0 when nothing is granted)
//   out_valid  result valid
//   out_ready  downstream accept
//   out_chan   channel index of the result
//   out_sum    sum of the sample and its three predecessors, w+2 bits
//
// Optional feature macro: FIR_SCHED_CLR_EN adds the chan_clr input.

module fir_chan_sched #(
   parameter int unsigned w = 16,
   parameter int unsigned N = 4,
   localparam int unsigned CW = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset,
`ifdef FIR_SCHED_CLR_EN
   input  logic [N-1:0]    chan_clr,
`endif
   input  logic [N-1:0]    in_valid,
   input  logic [N*w-1:0]  in_data,
   output logic [N-1:0]    in_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [CW-1:0]   out_chan,
   output logic [w+1:0]    out_sum
);

   // Per-channel history: h0 is the most recent accepted sample.
   logic [N-1:0][w-1:0] h0_q, h1_q, h2_q;
   logic [CW-1:0]       ptr_q;

   // Stage 1 partial sums.
   logic [w:0]          p0_q, p1_q;
   logic [CW-1:0]       s1_chan_q;
   logic                s1_valid_q;

   // Stage 2 / output register.
   logic [w+1:0]        out_sum_q;
   logic [CW-1:0]       out_chan_q;
   logic                out_valid_q;

   logic                en;
   logic                accept;
   logic                gnt_any;
   logic [CW-1:0]       gnt_idx;
   logic [CW-1:0]       cand;
   logic [N-1:0]        grant;
   logic [N-1:0]        clr;
   logic [w-1:0]        sample;
   logic [w-1:0]        tap0, tap1, tap2;

`ifdef FIR_SCHED_CLR_EN
   assign clr = chan_clr;
`else
   assign clr = '0;
`endif

   // The whole pipeline advances unless a result is waiting on the sink.
   assign en = !out_valid_q || out_ready;

   // Round-robin search starting one past the last granted channel.
   // Only in_valid and the pointer feed the grant, never in_data.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand = CW'((32'(ptr_q) + i) % N);
         if (!gnt_any && in_valid[cand]) begin
            gnt_any     = 1'b1;
            gnt_idx     = cand;
            grant[cand] = 1'b1;
         end
      end
   end

   assign accept   = en && !reset && gnt_any;
   assign in_ready = accept ? grant : '0;

   // Granted sample and its history taps; a same-edge clear zeroes the taps
   // so the result reflects a freshly cleared history.
   always_comb begin
      sample = in_data[32'(gnt_idx) * w +: w];
      tap0   = clr[gnt_idx] ? '0 : h0_q[gnt_idx];
      tap1   = clr[gnt_idx] ? '0 : h1_q[gnt_idx];
      tap2   = clr[gnt_idx] ? '0 : h2_q[gnt_idx];
   end

   // History and round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         h0_q  <= '0;
         h1_q  <= '0;
         h2_q  <= '0;
         ptr_q <= CW'(N - 1);
      end else begin
         for (int c = 0; c < N; c++) begin
            if (accept && (gnt_idx == CW'(c))) begin
               h0_q[c] <= sample;
               h1_q[c] <= tap0;
               h2_q[c] <= tap1;
            end else if (clr[c]) begin
               // Clear applies even while the pipeline is stalled.
               h0_q[c] <= '0;
               h1_q[c] <= '0;
               h2_q[c] <= '0;
            end
         end
         if (accept) begin
            ptr_q <= gnt_idx;
         end
      end
   end

   // Stage 1: two (w+1)-bit partial sums from the pre-shift history.
   always_ff @(posedge clk) begin
      if (reset) begin
         p0_q       <= '0;
         p1_q       <= '0;
         s1_chan_q  <= '0;
         s1_valid_q <= 1'b0;
      end else if (en) begin
         if (accept) begin
            p0_q       <= {1'b0, sample} + {1'b0, tap0};
            p1_q       <= {1'b0, tap1} + {1'b0, tap2};
            s1_chan_q  <= gnt_idx;
            s1_valid_q <= 1'b1;
         end else begin
            s1_valid_q <= 1'b0;
         end
      end
   end

   // Stage 2: final sum; data holds when no new result arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_sum_q   <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (en) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_sum_q  <= {1'b0, p0_q} + {1'b0, p1_q};
            out_chan_q <= s1_chan_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_chan  = out_chan_q;
   assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_fir_chan_sched.sv
// Self-checking bench for fir_chan_sched. A negedge monitor keeps an
// independent model of grant order, channel histories and pipeline
// occupancy; the expected results are queued when a sample is accepted and
// popped when the output handshakes. The scenario tasks add directed checks.

module tb_fir_chan_sched;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int CW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    in_valid;
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic            out_ready;
   logic [CW-1:0]   out_chan;
   logic [W+1:0]    out_sum;
`ifdef FIR_SCHED_CLR_EN
   logic [N-1:0]    chan_clr;
`endif

   fir_chan_sched #(
      .w (W),
      .N (N)
   ) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef FIR_SCHED_CLR_EN
      .chan_clr  (chan_clr),
`endif
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_chan  (out_chan),
      .out_sum   (out_sum)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   typedef struct {
      logic [CW-1:0] chan;
      logic [W+1:0]  sum;
   } res_t;

   res_t sb_q[$];

   // Reference model state, equal to the DUT state after the last posedge.
   int  mh0[N];
   int  mh1[N];
   int  mh2[N];
   int  m_ptr  = N - 1;
   bit  m_s1v  = 1'b0;
   bit  m_ov   = 1'b0;
   bit  mon_en = 1'b0;

   initial begin
      for (int c = 0; c < N; c++) begin
         mh0[c] = 0;
         mh1[c] = 0;
         mh2[c] = 0;
      end
   end

   always @(negedge clk) begin : monitor
      logic [N-1:0] exp_rdy;
      logic [N-1:0] clr_m;
      int   g;
      int   cc;
      int   smp, t0, t1, t2;
      bit   en_m;
      res_t r;
      if (mon_en) begin
         clr_m = '0;
`ifdef FIR_SCHED_CLR_EN
         clr_m = chan_clr;
`endif
         en_m    = !m_ov || out_ready;
         exp_rdy = '0;
         g       = -1;
         if (en_m && !reset) begin
            for (int i = 1; i <= N; i++) begin
               cc = (m_ptr + i) % N;
               if (g < 0 && in_valid[cc]) g = cc;
            end
         end
         if (g >= 0) exp_rdy[g] = 1'b1;

         n_checks++;
         if (in_ready !== exp_rdy) begin
            n_fails++;
            $display("FAIL grant: in_ready=%b expected %b", in_ready, exp_rdy);
         end
         n_checks++;
         if (out_valid !== m_ov) begin
            n_fails++;
            $display("FAIL out_valid: got %b expected %b", out_valid, m_ov);
         end
         if (m_ov) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_fails++;
               $display("FAIL scoreboard: result chan=%0d sum=%0d with nothing expected",
                        out_chan, out_sum);
            end else begin
               if (out_chan !== sb_q[0].chan || out_sum !== sb_q[0].sum) begin
                  n_fails++;
                  $display("FAIL scoreboard: got chan=%0d sum=%0d expected chan=%0d sum=%0d",
                           out_chan, out_sum, sb_q[0].chan, sb_q[0].sum);
               end
               if (out_ready && !reset) void'(sb_q.pop_front());
            end
         end

         // Advance the model to the state after the coming posedge.
         if (reset) begin
            for (int c = 0; c < N; c++) begin
               mh0[c] = 0;
               mh1[c] = 0;
               mh2[c] = 0;
            end
            m_ptr = N - 1;
            m_s1v = 1'b0;
            m_ov  = 1'b0;
            sb_q.delete();
         end else begin
            if (g >= 0) begin
               smp    = int'(in_data[g*W +: W]);
               t0     = clr_m[g] ? 0 : mh0[g];
               t1     = clr_m[g] ? 0 : mh1[g];
               t2     = clr_m[g] ? 0 : mh2[g];
               r.chan = CW'(g);
               r.sum  = 18'(smp + t0 + t1 + t2);
               sb_q.push_back(r);
               mh2[g] = t1;
               mh1[g] = t0;
               mh0[g] = smp;
               m_ptr  = g;
            end
            for (int c = 0; c < N; c++) begin
               if (clr_m[c] && c != g) begin
                  mh0[c] = 0;
                  mh1[c] = 0;
                  mh2[c] = 0;
               end
            end
            if (en_m) begin
               m_ov  = m_s1v;
               m_s1v = (g >= 0);
            end
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset     = 1'b1;
      in_valid  = '0;
      out_ready = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset    = 1'b1;
      in_valid = '1;
      #1;
      n_checks++;
      if (in_ready !== '0) begin
         n_fails++;
         $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0 || out_sum !== '0 || out_chan !== '0) begin
         n_fails++;
         $display("FAIL reset_outputs: valid=%b sum=%0d chan=%0d expected 0/0/0",
                  out_valid, out_sum, out_chan);
      end
      reset    = 1'b0;
      in_valid = '0;
   endtask

   task automatic test_single_ch;
      int exp_sum[5] = '{1, 3, 6, 10, 14};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         if (i < 5) begin
            in_valid      = 4'b0001;
            in_data[15:0] = 16'(i + 1);
         end else begin
            in_valid = '0;
         end
         step();
         if (i >= 1 && i <= 5) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_sum !== 18'(exp_sum[i-1])) begin
               n_fails++;
               $display("FAIL single_ch[%0d]: valid=%b chan=%0d sum=%0d expected 1/0/%0d",
                        i - 1, out_valid, out_chan, out_sum, exp_sum[i-1]);
            end
         end else if (i == 6) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
               n_fails++;
               $display("FAIL single_ch_drain: out_valid=%b expected 0", out_valid);
            end
         end
      end
   endtask

   task automatic test_all_channels;
      int ch2_exp[5] = '{300, 600, 900, 1200, 1200};
      int k = 0;
      logic [N-1:0] exp_g;
      do_reset();
      for (int c = 0; c < N; c++) in_data[c*W +: W] = 16'(100 * (c + 1));
      in_valid = '1;
      for (int i = 0; i < 24; i++) begin
         #1;
         if (i < 8) begin
            exp_g = 4'b0001 << (i % 4);
            n_checks++;
            if (in_ready !== exp_g) begin
               n_fails++;
               $display("FAIL rr_order[%0d]: in_ready=%b expected %b", i, in_ready, exp_g);
            end
         end
         step();
         if (out_valid === 1'b1 && out_chan === 2'd2 && k < 5) begin
            n_checks++;
            if (out_sum !== 18'(ch2_exp[k])) begin
               n_fails++;
               $display("FAIL ch2_sum[%0d]: got %0d expected %0d", k, out_sum, ch2_exp[k]);
            end
            k++;
         end
      end
      n_checks++;
      if (k != 5) begin
         n_fails++;
         $display("FAIL ch2_count: got %0d results expected 5", k);
      end
      in_valid = '0;
   endtask

   task automatic test_max;
      int k = 0;
      do_reset();
      in_data[31:16] = 16'hFFFF;
      for (int i = 0; i < 8; i++) begin
         in_valid = (i < 4) ? 4'b0010 : 4'b0000;
         step();
         if (out_valid === 1'b1 && out_chan === 2'd1 && k < 4) begin
            n_checks++;
            if (out_sum !== 18'(65535 * (k + 1))) begin
               n_fails++;
               $display("FAIL max_sum[%0d]: got %h expected %h", k, out_sum,
                        18'(65535 * (k + 1)));
            end
            k++;
         end
      end
      n_checks++;
      if (k != 4 || out_valid !== 1'b0 || in_ready !== '0) begin
         n_fails++;
         $display("FAIL max_idle: results=%0d valid=%b in_ready=%b expected 4/0/0000",
                  k, out_valid, in_ready);
      end
   endtask

   task automatic test_stall;
      do_reset();
      in_valid      = 4'b0001;
      in_data[15:0] = 16'd5;
      step();
      in_data[15:0] = 16'd6;
      step();
      out_ready     = 1'b0;
      in_data[15:0] = 16'd7;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (in_ready !== '0 || out_valid !== 1'b1 || out_sum !== 18'd5 || out_chan !== 2'd0) begin
            n_fails++;
            $display("FAIL stall[%0d]: in_ready=%b valid=%b sum=%0d chan=%0d expected 0000/1/5/0",
                     i, in_ready, out_valid, out_sum, out_chan);
         end
         step();
      end
      out_ready = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 18'd11) begin
         n_fails++;
         $display("FAIL stall_release: valid=%b sum=%0d expected 1/11", out_valid, out_sum);
      end
      in_valid = '0;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 18'd18) begin
         n_fails++;
         $display("FAIL stall_history: valid=%b sum=%0d expected 1/18", out_valid, out_sum);
      end
      step();
   endtask

   task automatic test_reset_mid;
      do_reset();
      in_data[15:0]  = 16'd11;
      in_data[31:16] = 16'd22;
      in_valid       = 4'b0011;
      step();
      step();
      step();
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fails++;
         $display("FAIL mid_pre: out_valid=%b expected 1", out_valid);
      end
      reset = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b0 || out_sum !== '0 || out_chan !== '0) begin
         n_fails++;
         $display("FAIL mid_reset: valid=%b sum=%0d chan=%0d expected 0/0/0",
                  out_valid, out_sum, out_chan);
      end
      reset         = 1'b0;
      in_data[15:0] = 16'd7;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin
         n_fails++;
         $display("FAIL mid_priority: in_ready=%b expected 0001", in_ready);
      end
      step();
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_sum !== 18'd7) begin
         n_fails++;
         $display("FAIL mid_after: valid=%b chan=%0d sum=%0d expected 1/0/7",
                  out_valid, out_chan, out_sum);
      end
      in_valid = '0;
      step();
      step();
   endtask

`ifdef FIR_SCHED_CLR_EN
   task automatic test_clr;
      int samples[5] = '{10, 20, 30, 5, 1};
      do_reset();
      in_valid = 4'b1000;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) begin
            in_data[63:48] = 16'(samples[i]);
            chan_clr       = (i == 3) ? 4'b1000 : 4'b0000;
         end else begin
            in_valid = '0;
            chan_clr = '0;
         end
         step();
         if (i == 4) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_chan !== 2'd3 || out_sum !== 18'd5) begin
               n_fails++;
               $display("FAIL clr_same_edge: valid=%b chan=%0d sum=%0d expected 1/3/5",
                        out_valid, out_chan, out_sum);
            end
         end else if (i == 5) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_chan !== 2'd3 || out_sum !== 18'd6) begin
               n_fails++;
               $display("FAIL clr_next: valid=%b chan=%0d sum=%0d expected 1/3/6",
                        out_valid, out_chan, out_sum);
            end
         end
      end
      step();
   endtask
`endif

   initial begin
      reset     = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b1;
`ifdef FIR_SCHED_CLR_EN
      chan_clr  = '0;
`endif
      step();
      mon_en = 1'b1;
      test_reset();
      test_single_ch();
      test_all_channels();
      test_max();
      test_stall();
      test_reset_mid();
`ifdef FIR_SCHED_CLR_EN
      test_clr();
`endif
      in_valid = '0;
      repeat (5) step();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fails++;
         $display("FAIL scoreboard_empty: %0d results pending expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
